aes_round_finish: RTL
=====================

// Module: aes_round_finish
// PURPOSE
// - Registered round-completion stage of the AES-128 encrypt datapath; consumes the 128-bit SubBytes output.
// - Applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey, then registers the result.
// - Valid/ready handshake on both sides; output feeds the next round's SubBytes or the ciphertext port.
// - Byte order: byte k = bits [127-8k -: 8]; state[r][c] = byte r+4c (FIPS-197 column-major).
// PARAMETERS
// - NR     10  last round index; MixColumns is skipped when in_round == NR
// - TAG_W  4   width of sideband tag carried alongside each state, unmodified
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      in_state/in_key/in_round/in_tag valid
// - in_ready   out  1      stage can accept this cycle
// - in_state   in   128    SubBytes output
// - in_key     in   128    round key for this round
// - in_round   in   4      round index, legal 1..NR
// - in_tag     in   TAG_W  sideband tag
// - out_valid  out  1      output register holds a result
// - out_ready  in   1      downstream accepts
// - out_state  out  128    round result
// - out_round  out  4      in_round of this result
// - out_tag    out  TAG_W  in_tag of this result
// - out_last   out  1      1 when out_round == NR
// - out_err    out  1      1 when out_round == 0 or out_round > NR (result still computed, MixColumns applied)
// BEHAVIOUR
// - Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
// - Reset (async, rst_n low): out_valid=0, out_state=0, out_round=0, out_tag=0, out_last=0, out_err=0;
//   skid entry emptied; in_ready=1 from the first edge after rst_n rises. In-flight data discarded.
// - Datapath, purely combinational between input and output register:
//   sr[r][c] = in[r][(c+r) mod 4]; mc = MixColumns(sr) over GF(2^8), poly 0x11B, xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0);
//   res = (in_round == NR ? sr : mc) ^ in_key.
// - Latency 1 cycle: accepted on edge N -> out_valid=1 with result after edge N. Throughput 1 per cycle.
// - Output held stable (all out_* bits) while out_valid && !out_ready.
// - Simultaneous in and out transfer on the same edge: new result replaces old; out_valid stays 1.
// - in_ready never depends on in_valid; in_state etc. are ignored when no transfer occurs.
// CONFIGURATION
// - Macro AES_ROUND_FINISH_SKID_EN.
// - Defined: 2-entry buffer (output reg + skid reg); in_ready is a register output = !skid_full.
//   Transfer in while out_valid && !out_ready -> captured into skid; next cycle in_ready=0.
//   On out transfer with skid_full, skid moves to output, skid_full=0. Order strictly preserved.
//   Both entries cleared by reset.
// - Not defined: single output register; in_ready = !out_valid || out_ready (combinational from out_ready).
// - Cycle-level output sequence identical in both builds whenever out_ready is held 1.
// TESTING
// - FIPS-197 B round 1: in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605,
//   in_round=1 -> out_state=a49c7ff2689f352b6b5bea43026a5049, out_last=0, out_err=0, one cycle later.
// - Final round: in_state=000102030405060708090a0b0c0d0e0f, in_key=0, in_round=10 ->
//   out_state=00050a0f04090e03080d02070c01060b, out_last=1.
// - Back-pressure: 3 back-to-back inputs tags 1,2,3, out_ready low 4 cycles then high -> tags emerge 1,2,3
//   in order, no loss/duplication; out_* stable while stalled; in_ready per configured build.
// - Illegal round: in_round=0 and in_round=11 -> out_err=1, out_last=0, out_state = MixColumns path result.
// - Reset mid-stream: rst_n low asynchronously while out_valid=1 and stalled -> out_valid=0 immediately
//   (no clock edge); after release nothing from before reset emerges.
// - Streaming: 20 random vectors, out_ready=1, in_valid=1 every cycle -> one result per cycle, matches
//   software model, in_ready constantly 1.

Source files
------------

// File: rtl/aes_round_finish.sv
// AES-128 round-completion stage: ShiftRows, MixColumns (bypassed on round NR), AddRoundKey, registered output.
// Define AES_ROUND_FINISH_SKID_EN for a 2-entry output buffer with a registered in_ready.
module aes_round_finish #(
   parameter int unsigned NR    = 10,
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_state,
   input  logic [127:0]       in_key,
   input  logic [3:0]         in_round,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       out_state,
   output logic [3:0]         out_round,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_last,
   output logic               out_err
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef struct packed {
      logic [127:0]     state;
      logic [3:0]       round;
      logic [TAG_W-1:0] tag;
      logic             last;
      logic             err;
   } entry_t;

   entry_t       in_ent;
   entry_t       out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic         in_fire, out_fire;
   logic [127:0] sr_w, mc_w;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // col = {row0, row1, row2, row3} of one state column
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] s0, s1, s2, s3;
      s0 = col[31:24];
      s1 = col[23:16];
      s2 = col[15:8];
      s3 = col[7:0];
      return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
              s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
              s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
              xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
   endfunction

   always_comb begin
      sr_w = '0;
      mc_w = '0;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            sr_w[127-8*(r+4*c) -: 8] = in_state[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         mc_w[127-32*c -: 32] = mix_col(sr_w[127-32*c -: 32]);
      end
   end

   always_comb begin
      in_ent.state = ((in_round == LAST_RND) ? sr_w : mc_w) ^ in_key;
      in_ent.round = in_round;
      in_ent.tag   = in_tag;
      in_ent.last  = (in_round == LAST_RND);
      in_ent.err   = (in_round == 4'd0) || (in_round > LAST_RND);
   end

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

`ifdef AES_ROUND_FINISH_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_full_q, skid_full_d;
   logic   in_ready_q, in_ready_d;

   // in_ready is withheld while the skid entry is occupied; a full skid always drains before new input
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      skid_full_d = skid_full_q;
      skid_d      = skid_q;
      if (skid_full_q) begin
         if (out_ready) begin
            out_d       = skid_q;
            skid_full_d = 1'b0;
         end
      end else if (in_fire) begin
         if (out_valid_q && !out_ready) begin
            skid_d      = in_ent;
            skid_full_d = 1'b1;
         end else begin
            out_d       = in_ent;
            out_valid_d = 1'b1;
         end
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
      in_ready_d = !skid_full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q      <= '0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;
`else
   logic rdy_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (in_fire) begin
         out_d       = in_ent;
         out_valid_d = 1'b1;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   // rdy_q holds in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   assign in_ready = rdy_q && (!out_valid_q || out_ready);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_q.state;
   assign out_round = out_q.round;
   assign out_tag   = out_q.tag;
   assign out_last  = out_q.last;
   assign out_err   = out_q.err;

endmodule
